// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and constants for the clock-divider run controller
package clk_div_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;
    localparam int MIN_DIV = 2;
    localparam int DEF_DIV = 33;
endpackage

// File: rtl/clk_div_sched_counter.sv
// div_counter: period counter whose terminal and high-phase flags are registered against the next count
module div_counter #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         run,
    input  logic         clear,
    input  logic [W-1:0] div,
    output logic [W-1:0] cnt,
    output logic         terminal,
    output logic         high
);
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] half;
    // half = ceil(div/2) without a W+1-bit sum, so div = 2^W-1 cannot overflow
    always_comb begin
        cnt_nxt = (clear || !run || terminal) ? '0 : cnt + W'(1);
        half = (div >> 1) + {{(W-1){1'b0}}, div[0]};
    end
    // flags describe the cycle being entered, with div already the divisor in effect then
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt <= '0;
            terminal <= 1'b0;
            high <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            terminal <= !clear && (cnt_nxt == div - W'(1));
            high <= !clear && (cnt_nxt < half);
        end
    end
endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: run controller that starts/stops the divider and swaps divisors only at period boundaries
module clk_div_sched #(
    parameter int W = 8,
    parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic         div_req,
    input  logic [W-1:0] div_val,
    output logic         div_ack,
    output logic         div_err,
    output logic         busy,
    output logic         tick,
    output logic         clk_div_out,
    output logic         running,
    output logic [W-1:0] cur_div
);
    import clk_div_pkg::*;
    state_t state, state_nxt;
    logic [W-1:0] pend_div, cur_div_nxt, pend_div_nxt, cnt;
    logic ack_nxt, err_nxt, valid;
    assign valid = div_val >= W'(MIN_DIV);
    // next state, divisor bookkeeping and handshake pulses; tick marks the terminal cycle
    always_comb begin
        state_nxt = state;
        cur_div_nxt = cur_div;
        pend_div_nxt = pend_div;
        ack_nxt = 1'b0;
        err_nxt = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = en ? RUN : IDLE;
                cur_div_nxt = (div_req && valid) ? div_val : cur_div;
                ack_nxt = div_req && valid;
                err_nxt = div_req && !valid;
            end
            RUN: begin
                state_nxt = (tick && !en) ? IDLE : RUN;
                if (div_req && !valid) err_nxt = 1'b1;
                else if (div_req && tick && !en) begin
                    cur_div_nxt = div_val;
                    ack_nxt = 1'b1;
                end else if (div_req) begin
                    state_nxt = PEND;
                    pend_div_nxt = div_val;
                end
            end
            PEND: begin
                err_nxt = div_req;
                if (tick) begin
                    state_nxt = en ? RUN : IDLE;
                    cur_div_nxt = pend_div;
                    ack_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    // state, divisors and all status outputs are flops
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
            cur_div <= W'(DEF_DIV);
            pend_div <= '0;
            div_ack <= 1'b0;
            div_err <= 1'b0;
            running <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_nxt;
            cur_div <= cur_div_nxt;
            pend_div <= pend_div_nxt;
            div_ack <= ack_nxt;
            div_err <= err_nxt;
            running <= state_nxt != IDLE;
            busy <= state_nxt == PEND;
        end
    end
    div_counter #(.W(W)) u_cnt (
        .clk_in(clk_in),
        .rst(rst),
        .run(state != IDLE),
        .clear(state_nxt == IDLE),
        .div(cur_div_nxt),
        .cnt(cnt),
        .terminal(tick),
        .high(clk_div_out)
    );
    // the counter only ever rests at zero
    a_idle_zero: assert property (@(posedge clk_in) disable iff (rst) state == IDLE |-> cnt == '0);
endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: scoreboard bench for the clock-divider run controller
module tb_clk_div_sched;
    logic clk_in = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic div_req = 1'b0;
    logic [7:0] div_val = '0;
    logic div_ack, div_err, busy, tick, clk_div_out, running;
    logic [7:0] cur_div;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int base = 0;
    int per = 33;
    bit run_exp = 1'b0;
    int tick_q[$];
    int ack_q[$];
    int err_q[$];

    clk_div_sched #(.W(8), .DEF_DIV(33)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .en(en),
        .div_req(div_req),
        .div_val(div_val),
        .div_ack(div_ack),
        .div_err(div_err),
        .busy(busy),
        .tick(tick),
        .clk_div_out(clk_div_out),
        .running(running),
        .cur_div(cur_div)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic pop_chk(input int kind);
        int exp;
        string name;
        name = kind == 0 ? "tick" : kind == 1 ? "div_ack" : "div_err";
        exp = -1;
        if (kind == 0 && tick_q.size() > 0) exp = tick_q.pop_front();
        if (kind == 1 && ack_q.size() > 0) exp = ack_q.pop_front();
        if (kind == 2 && err_q.size() > 0) exp = err_q.pop_front();
        checks++;
        if (exp != cyc) begin
            errors++;
            $display("FAIL %s pulse at cyc=%0d, required at cyc=%0d (-1: none expected)", name, cyc, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (tick) pop_chk(0);
        if (div_ack) pop_chk(1);
        if (div_err) pop_chk(2);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (run_exp && (cyc + 1 - base) % per == per - 1) tick_q.push_back(cyc + 1);
            step();
            chk("clk_div_out", clk_div_out, run_exp && ((cyc - base) % per < (per + 1) / 2));
            chk("running", running, run_exp);
        end
    endtask

    task automatic until_cnt(input int k);
        for (int i = 0; i < 256 && (cyc - base) % per != k; i++) run(1);
    endtask

    task automatic bad(input int v);
        err_q.push_back(cyc + 1);
        div_req = 1'b1;
        div_val = 8'(v);
        run(1);
        div_req = 1'b0;
        chk("bad_cur_div", cur_div, per);
        chk("bad_busy", busy, 0);
    endtask

    task automatic change(input int v, input bit dup);
        int c, term;
        c = (cyc - base) % per;
        term = (c == per - 1) ? cyc + per : cyc + per - 1 - c;
        ack_q.push_back(term + 1);
        div_req = 1'b1;
        div_val = 8'(v);
        run(1);
        div_req = 1'b0;
        chk("busy_set", busy, 1);
        if (dup) begin
            err_q.push_back(cyc + 1);
            div_req = 1'b1;
            div_val = 8'd7;
            run(1);
            div_req = 1'b0;
            chk("pend_busy", busy, 1);
        end
        run(term - cyc);
        chk("busy_hold", busy, 1);
        chk("cur_div_old", cur_div, per);
        base = term + 1;
        per = v;
        run(1);
        chk("busy_clr", busy, 0);
        chk("cur_div_new", cur_div, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        run(3);
        chk("rst_cur_div", cur_div, 33);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ack", div_ack, 0);
        chk("rst_err", div_err, 0);
        rst = 1'b0;
        en = 1'b1;
        base = cyc + 1;
        run_exp = 1'b1;
        run(200);
        chk("run_cur_div", cur_div, 33);
        until_cnt(10);
        change(4, 1'b0);
        run(8);
        bad(1);
        bad(0);
        until_cnt(3);
        change(5, 1'b1);
        run(10);
        until_cnt(1);
        change(33, 1'b0);
        until_cnt(5);
        en = 1'b0;
        run(27);
        run_exp = 1'b0;
        run(40);
        chk("stop_busy", busy, 0);
        chk("stop_cur_div", cur_div, 33);
        bad(1);
        bad(0);
        ack_q.push_back(cyc + 1);
        div_req = 1'b1;
        div_val = 8'd6;
        run(1);
        div_req = 1'b0;
        per = 6;
        chk("idle_cur_div", cur_div, 6);
        en = 1'b1;
        base = cyc + 1;
        run_exp = 1'b1;
        run(20);
        until_cnt(2);
        change(33, 1'b0);
        until_cnt(10);
        div_req = 1'b1;
        div_val = 8'd5;
        run(1);
        div_req = 1'b0;
        chk("pre_rst_busy", busy, 1);
        until_cnt(20);
        rst = 1'b1;
        run_exp = 1'b0;
        run(1);
        rst = 1'b0;
        chk("rst2_busy", busy, 0);
        chk("rst2_cur_div", cur_div, 33);
        chk("rst2_ack", div_ack, 0);
        base = cyc + 1;
        run_exp = 1'b1;
        run(70);
        @(negedge clk_in);
        #1;
        chk("tick_left", tick_q.size(), 0);
        chk("ack_left", ack_q.size(), 0);
        chk("err_left", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
Run controller for the programmable integer clock divider.
- Starts and stops the divider.
- Accepts new divide ratios over a req/ack handshake.
- Applies a new ratio only at a period boundary, so no runt or stretched period appears on the output.
- Outputs are a single-cycle tick enable and a divided square wave.
- Sits between control logic (FSMs, buttons) and every consumer of slow clock-enables. Single clock domain, no negedge logic.

Parameters:
W, 8, width of divisor and counter
DEF_DIV, 33, divisor loaded at reset (must be 2..2^W-1)

Ports:
clk_in  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  level; 1 = run divider, 0 = stop at end of current period
div_req  in  1  one-cycle pulse; request new divisor
div_val  in  W  requested divisor, sampled when div_req=1
div_ack  out  1  one-cycle pulse; requested divisor now in effect
div_err  out  1  one-cycle pulse; request rejected
busy  out  1  a divisor change is pending
tick  out  1  one-cycle pulse at last cycle of each divided period
clk_div_out  out  1  divided square wave
running  out  1  1 while state RUN or PEND
cur_div  out  W  divisor currently in effect

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst, and overrides everything including a pending change.
- Reset values: state=IDLE, cnt=0, cur_div=DEF_DIV, pend_div=0. tick, clk_div_out, div_ack, div_err, busy and running all 0.
- States:
  - IDLE: counter held at 0, all outputs low.
  - RUN: counting.
  - PEND: counting with a change queued.
- Counter: cnt counts 0..cur_div-1 and wraps to 0.
  - tick = (cnt==cur_div-1) and running.
  - clk_div_out = running and (cnt < (cur_div+1)>>1). For odd N it is high (N+1)/2 cycles, low (N-1)/2; for N=33 that is 17 high, 16 low.
  - All outputs are registered. Compares use W-bit unsigned arithmetic, no overflow at 2^W-1.
- IDLE -> RUN: when en=1 is sampled. The next cycle has cnt=0. The first tick comes in the cur_div-th cycle of RUN.
- Stopping: en=0 in RUN or PEND does not stop immediately. The current period completes; in the terminal cycle (cnt=cur_div-1) the FSM goes to IDLE. Re-asserting en before the terminal cycle cancels the stop.
- Divisor request validity: valid iff div_val>=2. Invalid requests give div_err the next cycle; state and cur_div are unchanged.
- Valid request in IDLE: cur_div<=div_val, div_ack the next cycle.
- Valid request in RUN:
  - pend_div<=div_val, go to PEND, busy=1 from the next cycle.
  - At the terminal cycle: cur_div<=pend_div, cnt<=0, PEND->RUN (or ->IDLE if en=0), busy<=0.
  - div_ack fires in the cycle after the terminal cycle, i.e. the first cycle of the new period.
- div_req while PEND: rejected with div_err; the pending value is kept.
- Request in the same cycle as the terminal cycle in RUN: it becomes pending and is applied at the following terminal cycle, not the current one.
- A new divisor never shortens or stretches the period in progress.

Decomposition:
- Package clk_div_pkg:
  - state typedef/encoding (IDLE=2'd0, RUN=2'd1, PEND=2'd2);
  - constant MIN_DIV=2;
  - default DEF_DIV=33.
- Sub-module div_counter:
  - inputs: clk_in, rst, run, clear, div;
  - outputs: cnt, terminal, high-phase compare.
- The FSM, handshake and pending register stay in clk_div_sched.

Test Plan:
1. Reset, en=1 held for 200 cycles, DEF_DIV=33 -> ticks exactly 33 cycles apart, first in the 33rd RUN cycle; clk_div_out 17 high / 16 low each period; cur_div=33.
2. In RUN, div_req with div_val=4 at cnt=10 -> busy=1; the current 33-cycle period completes; then periods of 4 (2 high / 2 low); div_ack in the first cycle of the first 4-period; busy=0.
3. div_val=1, then div_val=0 (in IDLE and in RUN) -> div_err pulse each; cur_div and period unchanged; no div_ack.
4. Second div_req (div_val=7) while PEND from a div_val=5 request -> div_err; divisor 5 is applied, never 7.
5. en dropped at cnt=5 with cur_div=33 -> runs to cnt=32, tick, then IDLE; clk_div_out=0 and running=0; no partial period.
6. rst asserted in PEND at cnt=20 -> next cycle IDLE, cur_div=33, busy=0, no div_ack; with en=1 held, counting restarts with the 33 period.
